// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM encodings,
// common constants and small op-classification helpers.
package mem_access_pkg;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Unknown op codes fall into neither class and therefore behave like NOP.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
      MEM_LW, MEM_SW:          return addr_lo != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for the load/store unit: byte enables and replicated store
// data towards the bus, lane extraction and sign/zero extension on the way back.
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be    = 4'b0000;
    wdata = ZERO_WORD;
    ldata = ZERO_WORD;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << addr_lo;
      MEM_LH, MEM_LHU, MEM_SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:          be = 4'b1111;
      default:                 be = 4'b0000;
    endcase
    case (op)
      MEM_SB:  wdata = {4{sdata[7:0]}};
      MEM_SH:  wdata = {2{sdata[15:0]}};
      MEM_SW:  wdata = sdata;
      default: wdata = ZERO_WORD;
    endcase
    case (op)
      MEM_LB:  ldata = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ldata = {24'h000000, byte_sel};
      MEM_LH:  ldata = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ldata = {16'h0000, half_sel};
      MEM_LW:  ldata = rdata;
      default: ldata = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: issues req/ack bus accesses for EX_MEM memory ops,
// stalls the pipeline while outstanding, and drives the MEM_WB write-back fields.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stall_req_o,
  output logic        exc_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ldata;
  logic        op_load;
  logic        op_store;
  logic        op_mem;
  logic        op_misaligned;
  logic        timed_out;

  mem_lane u_lane (
    .op      (mem_op_i),
    .addr_lo (mem_addr_i[1:0]),
    .sdata   (mem_sdata_i),
    .rdata   (rdata_q),
    .be      (lane_be),
    .wdata   (lane_wdata),
    .ldata   (lane_ldata)
  );

  always_comb begin
    op_load       = is_load(mem_op_i);
    op_store      = is_store(mem_op_i);
    op_mem        = op_load | op_store;
    op_misaligned = is_misaligned(mem_op_i, mem_addr_i[1:0]);
    timed_out     = (cnt_q == TIMEOUT_CNT);
  end

  // The counter holds the number of REQ cycles already spent without ack; once it
  // reaches TIMEOUT the following REQ cycle is the abort cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= ZERO_WORD;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= 8'd0;
          if (op_mem && !op_misaligned) state_q <= S_REQ;
        end
        S_REQ: begin
          if (timed_out) begin
            state_q <= S_IDLE;
          end else if (bus_ack_i) begin
            rdata_q <= bus_rdata_i;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is low so an abandoned access drops
  // its request without waiting for a clock edge.
  always_comb begin
    bus_req_o   = DISABLE;
    bus_we_o    = DISABLE;
    bus_addr_o  = ZERO_WORD;
    bus_be_o    = 4'b0000;
    bus_wdata_o = ZERO_WORD;
    wb_wd_o     = 5'd0;
    wb_wreg_o   = DISABLE;
    wb_wdata_o  = ZERO_WORD;
    stall_req_o = DISABLE;
    exc_o       = DISABLE;
    if (rst_i) begin
      wb_wd_o = mem_wd_i;
      case (state_q)
        S_IDLE: begin
          if (!op_mem) begin
            wb_wreg_o  = mem_wreg_i;
            wb_wdata_o = mem_wdata_i;
          end else if (op_misaligned) begin
            exc_o = ENABLE;
          end else begin
            stall_req_o = ENABLE;
          end
        end
        S_REQ: begin
          if (timed_out) begin
            exc_o = ENABLE;
          end else begin
            bus_req_o   = ENABLE;
            bus_we_o    = op_store;
            bus_addr_o  = {mem_addr_i[31:2], 2'b00};
            bus_be_o    = lane_be;
            bus_wdata_o = lane_wdata;
            stall_req_o = ENABLE;
          end
        end
        S_DONE: begin
          if (op_load) begin
            wb_wreg_o  = mem_wreg_i;
            wb_wdata_o = lane_ldata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed scoreboard bench for mem_access; the bench plays the memory side of the
// bus and compares each retiring instruction against its own load/store model.
module tb_mem_access;

  localparam int TIMEOUT = 4;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        exc;
    int          stalls;
    int          reqs;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        stall_req_o;
  logic        exc_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_mis    = 0;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .wb_wd_o     (wb_wd_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_wdata_o  (wb_wdata_o),
    .stall_req_o (stall_req_o),
    .exc_o       (exc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic bit m_is_load(input logic [3:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit m_misaligned(input logic [3:0] op, input logic [1:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0] == 1'b1;
    if (op == OP_LW || op == OP_SW) return a != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [1:0] a);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 4'(1 << a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] s);
    if (op == OP_SB) return {s[7:0], s[7:0], s[7:0], s[7:0]};
    if (op == OP_SH) return {s[15:0], s[15:0]};
    return s;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] a,
                                         input logic [31:0] r);
    logic [31:0] s;
    s = r >> (int'(a) * 8);
    case (op)
      OP_LB:   return {{24{s[7]}}, s[7:0]};
      OP_LBU:  return {24'h0, s[7:0]};
      OP_LH:   return {{16{s[15]}}, s[15:0]};
      OP_LHU:  return {16'h0, s[15:0]};
      default: return r;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_mis++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // Called just after a rising edge; drives one EX_MEM instruction, answers the
  // bus as memory (ack on the ack_after-th REQ cycle, 0 = never) and checks on
  // falling edges until the instruction retires (stall low).
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [4:0] wd,
                               input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int ack_after,
                               input bit ack_idle);
    exp_t e;
    int   stalls  = 0;
    int   reqs    = 0;
    bit   done    = 0;
    bit   bus_seen = 0;

    mem_op_i    = op;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
    mem_wdata_i = wdata;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;

    e.wd = wd; e.wreg = 1'b0; e.wdata = 32'h0; e.exc = 1'b0; e.stalls = 0; e.reqs = 0;
    if (!m_is_load(op) && !m_is_store(op)) begin
      e.wreg  = wreg;
      e.wdata = wdata;
    end else if (m_misaligned(op, addr[1:0])) begin
      e.exc = 1'b1;
    end else if (ack_after == 0) begin
      e.exc    = 1'b1;
      e.reqs   = TIMEOUT;
      e.stalls = 1 + TIMEOUT;
    end else begin
      e.reqs   = ack_after;
      e.stalls = 1 + ack_after;
      if (m_is_load(op)) begin
        e.wreg  = wreg;
        e.wdata = m_load(op, addr[1:0], rdata);
      end
    end
    sb.push_back(e);

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk_i);
      if (bus_req_o) begin
        reqs++;
        if (!bus_seen) begin
          bus_seen = 1;
          checkOutput({tag, " bus_addr"}, bus_addr_o, {addr[31:2], 2'b00});
          checkOutput({tag, " bus_we"}, 32'(bus_we_o), 32'(m_is_store(op)));
          checkOutput({tag, " bus_be"}, 32'(bus_be_o), 32'(m_be(op, addr[1:0])));
          if (m_is_store(op))
            checkOutput({tag, " bus_wdata"}, bus_wdata_o, m_store(op, sdata));
        end
        if (ack_after != 0 && reqs == ack_after) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = rdata;
        end else begin
          bus_ack_i   = 1'b0;
          bus_rdata_i = 32'hDEAD_BEEF;
        end
      end else begin
        bus_ack_i   = ack_idle;
        bus_rdata_i = 32'h5555_AAAA;
      end
      if (!stall_req_o) begin
        e = sb.pop_front();
        checkOutput({tag, " wb_wreg"}, 32'(wb_wreg_o), 32'(e.wreg));
        if (e.wreg) begin
          checkOutput({tag, " wb_wd"}, 32'(wb_wd_o), 32'(e.wd));
          checkOutput({tag, " wb_wdata"}, wb_wdata_o, e.wdata);
        end
        checkOutput({tag, " exc"}, 32'(exc_o), 32'(e.exc));
        checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(e.stalls));
        checkOutput({tag, " req cycles"}, 32'(reqs), 32'(e.reqs));
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checkOutput({tag, " retire within budget"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(posedge clk_i);
    #1;
    bus_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b0;
    mem_op_i    = OP_NOP;
    mem_wd_i    = 5'd5;
    mem_wreg_i  = 1'b1;
    mem_wdata_i = 32'h1234;
    mem_addr_i  = 32'h0;
    mem_sdata_i = 32'h0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;

    repeat (2) @(negedge clk_i);
    checkOutput("reset wb_wd", 32'(wb_wd_o), 32'd0);
    checkOutput("reset wb_wreg", 32'(wb_wreg_o), 32'd0);
    checkOutput("reset wb_wdata", wb_wdata_o, 32'd0);
    checkOutput("reset stall", 32'(stall_req_o), 32'd0);
    checkOutput("reset bus_req", 32'(bus_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    applyStimulus("nop",        OP_NOP, 5'd5,  1'b1, 32'h0000_1234, 32'h0,         32'h0,         32'h0,         0, 1'b1);
    applyStimulus("lb",         OP_LB,  5'd7,  1'b1, 32'h0,         32'h0000_0103, 32'h0,         32'h80FF_0000, 1, 1'b1);
    applyStimulus("sh",         OP_SH,  5'd9,  1'b1, 32'h0,         32'h0000_0102, 32'hABCD_1234, 32'h0,         3, 1'b0);
    applyStimulus("lw misalign",OP_LW,  5'd3,  1'b1, 32'h0,         32'h0000_0101, 32'h0,         32'h0,         1, 1'b0);
    applyStimulus("lw timeout", OP_LW,  5'd4,  1'b1, 32'h0,         32'h0000_0100, 32'h0,         32'h0,         0, 1'b0);
    applyStimulus("lbu",        OP_LBU, 5'd11, 1'b1, 32'h0,         32'h0000_0101, 32'h0,         32'h1234_8055, 2, 1'b0);
    applyStimulus("lh",         OP_LH,  5'd12, 1'b1, 32'h0,         32'h0000_0100, 32'h0,         32'h1234_8001, 1, 1'b0);
    applyStimulus("lhu",        OP_LHU, 5'd13, 1'b1, 32'h0,         32'h0000_0102, 32'h0,         32'h9ABC_0000, 1, 1'b0);
    applyStimulus("lw nowreg",  OP_LW,  5'd14, 1'b0, 32'h0,         32'h0000_0200, 32'h0,         32'hCAFE_BABE, 1, 1'b0);
    applyStimulus("lw",         OP_LW,  5'd15, 1'b1, 32'h0,         32'h0000_0204, 32'h0,         32'hCAFE_BABE, 2, 1'b1);
    applyStimulus("sb",         OP_SB,  5'd16, 1'b1, 32'h0,         32'h0000_0101, 32'h7777_775A, 32'h0,         1, 1'b0);
    applyStimulus("sw",         OP_SW,  5'd17, 1'b1, 32'h0,         32'h0000_010C, 32'h0123_4567, 32'h0,         2, 1'b0);
    applyStimulus("sh misalign",OP_SH,  5'd18, 1'b1, 32'h0,         32'h0000_0101, 32'h0,         32'h0,         1, 1'b0);
    applyStimulus("lh misalign",OP_LH,  5'd19, 1'b1, 32'h0,         32'h0000_0103, 32'h0,         32'h0,         1, 1'b0);
    applyStimulus("nop alu",    OP_NOP, 5'd31, 1'b1, 32'hFEDC_BA98, 32'h0000_0103, 32'h0,         32'h0,         0, 1'b0);

    mem_op_i    = OP_LHU;
    mem_wd_i    = 5'd21;
    mem_wreg_i  = 1'b1;
    mem_addr_i  = 32'h0000_0302;
    bus_ack_i   = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("rst mid req bus_req before", 32'(bus_req_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("rst mid req bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("rst mid req stall", 32'(stall_req_o), 32'd0);
    checkOutput("rst mid req bus_addr", bus_addr_o, 32'd0);
    checkOutput("rst mid req bus_be", 32'(bus_be_o), 32'd0);
    checkOutput("rst mid req wb_wd", 32'(wb_wd_o), 32'd0);
    checkOutput("rst mid req wb_wreg", 32'(wb_wreg_o), 32'd0);
    checkOutput("rst mid req exc", 32'(exc_o), 32'd0);
    @(posedge clk_i);
    #1;
    mem_op_i = OP_NOP;
    rst_i    = 1'b1;

    applyStimulus("nop after rst", OP_NOP, 5'd6, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus("lb after rst",  OP_LB,  5'd8, 1'b1, 32'h0, 32'h0000_0000, 32'h0, 32'h0000_007F, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_mis);
    $finish;
  end

endmodule
